// File: rtl/trap_check_pipe.sv
// trap_check_pipe: multi-slot MIPS conditional-trap check, one register stage
// plus a held exception request. Define TRAP_CNT_EN to build the trap counter.
module trap_check_pipe #(
  parameter int DATA_W = 32,
  parameter int N_SLOT = 2,
  parameter int TT_W   = 4,
  localparam int SW    = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [N_SLOT-1:0]        in_valid,
  input  logic [N_SLOT*TT_W-1:0]   in_trap_type,
  input  logic [N_SLOT*DATA_W-1:0] in_val1,
  input  logic [N_SLOT*DATA_W-1:0] in_val2,
  input  logic [N_SLOT*32-1:0]     in_pc,
  output logic                     in_ready,
  input  logic                     trap_ack,
  output logic                     exp_trap,
  output logic [SW-1:0]            exp_slot,
  output logic [31:0]              exp_pc,
  output logic [N_SLOT-1:0]        kill_mask,
  output logic [31:0]              trap_count
);

  localparam logic [TT_W-1:0] TT_TEQ  = TT_W'(1);
  localparam logic [TT_W-1:0] TT_TNE  = TT_W'(2);
  localparam logic [TT_W-1:0] TT_TGE  = TT_W'(3);
  localparam logic [TT_W-1:0] TT_TGEU = TT_W'(4);
  localparam logic [TT_W-1:0] TT_TLT  = TT_W'(5);
  localparam logic [TT_W-1:0] TT_TLTU = TT_W'(6);

  logic [N_SLOT-1:0]        s1_valid_q;
  logic [N_SLOT*TT_W-1:0]   s1_type_q;
  logic [N_SLOT*DATA_W-1:0] s1_a_q;
  logic [N_SLOT*DATA_W-1:0] s1_b_q;
  logic [N_SLOT*32-1:0]     s1_pc_q;

  logic                     exp_q, exp_d;
  logic [SW-1:0]            slot_q, slot_d;
  logic [31:0]              pc_q, pc_d;
  logic [N_SLOT-1:0]        kill_q, kill_d;

  logic [N_SLOT-1:0]        hit;
  logic                     found;
  logic [SW-1:0]            win_slot;
  logic [31:0]              win_pc;
  logic [N_SLOT-1:0]        win_kill;
  logic                     raise;

  assign in_ready = !exp_q;

  // S1 capture: flush kills, stall holds, bubbles while a request is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= '0;
    end else if (flush) begin
      s1_valid_q <= '0;
    end else if (!stall) begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        s1_type_q  <= in_trap_type;
        s1_a_q     <= in_val1;
        s1_b_q     <= in_val2;
        s1_pc_q    <= in_pc;
      end else begin
        s1_valid_q <= '0;
      end
    end
  end

  // per-slot trap condition evaluation
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      if (s1_valid_q[i]) begin
        unique case (s1_type_q[i*TT_W +: TT_W])
          TT_TEQ:  hit[i] = s1_a_q[i*DATA_W +: DATA_W] ==
                            s1_b_q[i*DATA_W +: DATA_W];
          TT_TNE:  hit[i] = s1_a_q[i*DATA_W +: DATA_W] !=
                            s1_b_q[i*DATA_W +: DATA_W];
          TT_TGE:  hit[i] = $signed(s1_a_q[i*DATA_W +: DATA_W]) >=
                            $signed(s1_b_q[i*DATA_W +: DATA_W]);
          TT_TGEU: hit[i] = s1_a_q[i*DATA_W +: DATA_W] >=
                            s1_b_q[i*DATA_W +: DATA_W];
          TT_TLT:  hit[i] = $signed(s1_a_q[i*DATA_W +: DATA_W]) <
                            $signed(s1_b_q[i*DATA_W +: DATA_W]);
          TT_TLTU: hit[i] = s1_a_q[i*DATA_W +: DATA_W] <
                            s1_b_q[i*DATA_W +: DATA_W];
          default: hit[i] = 1'b0;
        endcase
      end
    end
  end

  // oldest hitting slot wins; it and all younger valid slots get killed
  always_comb begin
    found    = 1'b0;
    win_slot = '0;
    win_pc   = '0;
    win_kill = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      if (hit[i] && !found) begin
        found    = 1'b1;
        win_slot = SW'(i);
        win_pc   = s1_pc_q[i*32 +: 32];
      end
      win_kill[i] = s1_valid_q[i] & found;
    end
  end

  // pending request next state: ack clears, new hit raises when idle
  always_comb begin
    exp_d  = exp_q;
    slot_d = slot_q;
    pc_d   = pc_q;
    kill_d = kill_q;
    raise  = !exp_q && found && !stall && !flush;
    if (exp_q && trap_ack) begin
      exp_d  = 1'b0;
      kill_d = '0;
    end else if (raise) begin
      exp_d  = 1'b1;
      slot_d = win_slot;
      pc_d   = win_pc;
      kill_d = win_kill;
    end
  end

  // pending request register
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q  <= 1'b0;
      slot_q <= '0;
      pc_q   <= '0;
      kill_q <= '0;
    end else begin
      exp_q  <= exp_d;
      slot_q <= slot_d;
      pc_q   <= pc_d;
      kill_q <= kill_d;
    end
  end

  assign exp_trap  = exp_q;
  assign exp_slot  = slot_q;
  assign exp_pc    = pc_q;
  assign kill_mask = kill_q;

`ifdef TRAP_CNT_EN
  logic [31:0] cnt_q;

  // count raised requests, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst)        cnt_q <= '0;
    else if (raise) cnt_q <= cnt_q + 32'd1;
  end

  assign trap_count = cnt_q;
`else
  assign trap_count = '0;
`endif

endmodule
